// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - fetch unit shared types, FSM states and bundle geometry helpers
package vliw_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } fetch_state_t;

    localparam int DEF_NFU                     = 2;
    localparam int DEF_PHYSICAL_ADDRESS_LENGTH = 56;

    function automatic int bundle_bits(input int nfu);
        return nfu * 32;
    endfunction

    function automatic int bundle_offset(input int nfu);
        return $clog2(nfu * 4);
    endfunction

    typedef struct packed {
        logic [DEF_PHYSICAL_ADDRESS_LENGTH-1:0] pc;
        logic [DEF_NFU*32-1:0]                  bundle;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, icache and decode handshake signals of the fetch unit
interface fetch_unit_if #(
    parameter int NFU                     = 2,
    parameter int PHYSICAL_ADDRESS_LENGTH = 56
);
    import vliw_fetch_pkg::*;

    localparam int BUNDLE_BITS = bundle_bits(NFU);

    logic                               redirect_valid;
    logic [PHYSICAL_ADDRESS_LENGTH-1:0] redirect_pc;
    logic [PHYSICAL_ADDRESS_LENGTH-1:0] ic_address;
    logic                               ic_do_fetch;
    logic                               ic_done_fetch;
    logic [BUNDLE_BITS-1:0]             ic_data;
    logic                               bundle_valid;
    logic                               bundle_ready;
    logic [BUNDLE_BITS-1:0]             bundle_data;
    logic [PHYSICAL_ADDRESS_LENGTH-1:0] bundle_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output ic_address, ic_do_fetch,
        input  ic_done_fetch, ic_data,
        output bundle_valid,
        input  bundle_ready,
        output bundle_data, bundle_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  ic_address, ic_do_fetch,
        output ic_done_fetch, ic_data,
        input  bundle_valid,
        output bundle_ready,
        input  bundle_data, bundle_pc
    );

endinterface

// File: rtl/fetch_unit_bundle_queue.sv
// rtl/fetch_unit_bundle_queue.sv - synchronous bundle FIFO with push, pop, flush and head outputs
module fetch_bundle_queue #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic             full;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign full       = (count == CW'(DEPTH));
    // Flush wins over both ends, so a pop in the flush cycle is discarded.
    assign do_push    = push && !flush;
    assign do_pop     = pop && head_valid && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) !(do_push && full));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - front-end fetch stage: owns the PC, issues icache requests, queues bundles for decode
module fetch_unit
    import vliw_fetch_pkg::*;
#(
    parameter int                                 NFU                     = 2,
    parameter int                                 PHYSICAL_ADDRESS_LENGTH = 56,
    parameter logic [PHYSICAL_ADDRESS_LENGTH-1:0] RESET_PC                = '0,
    parameter int                                 QUEUE_DEPTH             = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int BUNDLE_BITS   = bundle_bits(NFU);
    localparam int BUNDLE_OFFSET = bundle_offset(NFU);
    localparam int PAL           = PHYSICAL_ADDRESS_LENGTH;
    localparam int CW            = $clog2(QUEUE_DEPTH + 1);

    localparam logic [PAL-1:0] STEP       = PAL'(NFU * 4);
    localparam logic [PAL-1:0] ALIGN_MASK = ~((PAL'(1) << BUNDLE_OFFSET) - PAL'(1));

    fetch_state_t           state, state_n;
    logic [PAL-1:0]         pc, pc_n;
    logic [PAL-1:0]         addr_q, addr_n;
    logic                   fetch_q, fetch_n;
    logic                   squash, squash_n;
    logic                   push;
    logic                   flush;
    logic [CW-1:0]          q_count;
    logic [PAL+BUNDLE_BITS-1:0] head;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            addr_q  <= '0;
            fetch_q <= 1'b0;
            squash  <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            addr_q  <= addr_n;
            fetch_q <= fetch_n;
            squash  <= squash_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        addr_n   = addr_q;
        fetch_n  = fetch_q;
        squash_n = squash;
        push     = 1'b0;
        flush    = 1'b0;
        case (state)
            IDLE: begin
                // Only issue when a slot is free, so the response can always be pushed.
                if (q_count < CW'(QUEUE_DEPTH) && !bus.redirect_valid) begin
                    addr_n  = pc;
                    fetch_n = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                // Address stays frozen until done: the icache fills its line from it.
                if (bus.ic_done_fetch) begin
                    if (!squash && !bus.redirect_valid) begin
                        push = 1'b1;
                        pc_n = pc + STEP;
                    end
                    squash_n = 1'b0;
                    fetch_n  = 1'b0;
                    state_n  = GAP;
                end else if (bus.redirect_valid) begin
                    squash_n = 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (bus.redirect_valid) begin
            flush = 1'b1;
            pc_n  = bus.redirect_pc & ALIGN_MASK;
        end
    end

    fetch_bundle_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (PAL + BUNDLE_BITS)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({pc, bus.ic_data}),
        .pop        (bus.bundle_ready),
        .flush      (flush),
        .head_valid (bus.bundle_valid),
        .head_data  (head),
        .count      (q_count)
    );

    assign bus.ic_address  = addr_q;
    assign bus.ic_do_fetch = fetch_q;
    assign bus.bundle_pc   = head[PAL+BUNDLE_BITS-1:BUNDLE_BITS];
    assign bus.bundle_data = head[BUNDLE_BITS-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
    import vliw_fetch_pkg::*;

    localparam int             NFU = 2;
    localparam int             PAL = 56;
    localparam int             QD  = 2;
    localparam int             BB  = NFU * 32;
    localparam logic [PAL-1:0] RPC = 56'h1000;
    localparam logic [PAL-1:0] STEP_B = PAL'(NFU * 4);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.NFU(NFU), .PHYSICAL_ADDRESS_LENGTH(PAL)) bus ();

    fetch_unit #(
        .NFU                     (NFU),
        .PHYSICAL_ADDRESS_LENGTH (PAL),
        .RESET_PC                (RPC),
        .QUEUE_DEPTH             (QD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    fetch_entry_t   q[$];
    logic [PAL-1:0] exp_pc = RPC;
    logic [PAL-1:0] req_addr = '0;
    logic [PAL-1:0] last_req = '0;
    logic [PAL-1:0] redir_tgt = '0;
    logic [BB-1:0]  fixed_data = '0;
    bit squash = 0, prev_fetch = 0, redir_now = 0, redir_on_done = 0, force_done = 0;
    bit use_data = 0, watch_1008 = 0, saw_1008 = 0;
    int lat = 0, lat_fixed = 0, ready_mode = 0, redir_pct = 0, req_count = 0, last_wait = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, drive inputs, then advance the model for the coming posedge.
    task automatic cycle();
        logic f, v;
        logic [PAL-1:0] a, bp, tgt;
        logic [BB-1:0] bd, dat;
        bit rdy, rdr, dn, pop, forced;
        @(negedge clk);
        f = bus.ic_do_fetch; a = bus.ic_address;
        v = bus.bundle_valid; bp = bus.bundle_pc; bd = bus.bundle_data;
        check_eq("bundle_valid", v, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("bundle_pc", bp, q[0].pc);
            check_eq("bundle_data", bd, q[0].bundle);
        end
        if (watch_1008 && v && bp == 56'h1008) saw_1008 = 1;
        if (f && !prev_fetch) begin
            check_eq("req_addr", a, exp_pc);
            check_eq("issue_gate", q.size() < QD, 1);
            req_addr = exp_pc; last_req = a; req_count++;
            lat = (lat_fixed >= 0) ? lat_fixed : ($urandom_range(0, 7) == 0 ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3)));
        end else if (f) begin
            check_eq("addr_stable", a, req_addr);
        end
        prev_fetch = f;
        dn = (f && lat == 0) || force_done;
        if (f && lat > 0) lat--;
        rdy = (ready_mode == 2) ? bit'($urandom_range(0, 1)) : (ready_mode == 1);
        forced = redir_now || (redir_on_done && dn);
        rdr = forced || ($urandom_range(0, 99) < redir_pct);
        tgt = forced ? redir_tgt : PAL'({$urandom, $urandom});
        if (redir_on_done && dn) redir_on_done = 0;
        dat = use_data ? fixed_data : {$urandom, $urandom};
        bus.ic_done_fetch = dn; bus.ic_data = dat; bus.bundle_ready = rdy;
        bus.redirect_valid = rdr; bus.redirect_pc = tgt;
        redir_now = 0; force_done = 0;
        pop = (q.size() != 0) && rdy && !rdr;
        if (rdr) begin
            q.delete();
            exp_pc = tgt & ~(STEP_B - 1);
            if (f && !dn) squash = 1;
            else if (f && dn) squash = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (f && dn) begin
                if (!squash) begin
                    q.push_back('{pc: req_addr, bundle: dat});
                    exp_pc = req_addr + STEP_B;
                end
                squash = 0;
            end
        end
    endtask

    task automatic wait_req(input int budget, input logic [PAL-1:0] want, input string tag);
        int start = req_count;
        int n = 0;
        while (req_count == start && n < budget) begin
            cycle();
            n++;
        end
        last_wait = n;
        check_eq({tag, "_issued"}, req_count != start, 1);
        if (req_count != start) check_eq(tag, last_req, want);
    endtask

    task automatic do_reset(input bit stale_done);
        @(negedge clk);
        reset = 1'b1;
        bus.ic_done_fetch = stale_done; bus.ic_data = {$urandom, $urandom};
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.bundle_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_do_fetch", bus.ic_do_fetch, 0);
        check_eq("rst_address", bus.ic_address, 0);
        check_eq("rst_bundle_valid", bus.bundle_valid, 0);
        check_eq("rst_bundle_data", bus.bundle_data, 0);
        check_eq("rst_bundle_pc", bus.bundle_pc, 0);
        reset = 1'b0;
        q.delete(); exp_pc = RPC; squash = 0; prev_fetch = 0; lat = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.ic_done_fetch = 0; bus.ic_data = '0; bus.redirect_valid = 0;
        bus.redirect_pc = '0; bus.bundle_ready = 0;
        do_reset(0);

        // Hit path and 3-cycle cadence
        ready_mode = 0; lat_fixed = 0; use_data = 1; fixed_data = 64'hDEADBEEF_CAFEF00D;
        wait_req(4, 56'h1000, "hit_req");
        cycle();
        check_eq("hit_valid", bus.bundle_valid, 1);
        check_eq("hit_pc", bus.bundle_pc, 56'h1000);
        check_eq("hit_data", bus.bundle_data, 64'hDEADBEEF_CAFEF00D);
        use_data = 0;
        wait_req(4, 56'h1008, "hit_next_req");
        check_eq("hit_cadence", last_wait, 2);

        // Backpressure: queue fills and issue stops
        repeat (6) cycle();
        check_eq("bp_stall", bus.ic_do_fetch, 0);
        check_eq("bp_head_pc", bus.bundle_pc, 56'h1000);
        ready_mode = 1; cycle(); ready_mode = 0;
        wait_req(4, 56'h1010, "bp_next_req");

        // Redirect with a full queue and a same-cycle pop
        cycle();
        check_eq("flush_full_before", bus.bundle_valid, 1);
        ready_mode = 1; redir_now = 1; redir_tgt = 56'h3000;
        cycle();
        @(posedge clk); #1;
        check_eq("flush_valid", bus.bundle_valid, 0);
        wait_req(6, 56'h3000, "flush_req");

        // Long miss with a redirect in the middle
        do_reset(0);
        ready_mode = 1; lat_fixed = 10;
        wait_req(4, 56'h1000, "miss_req");
        cycle(); cycle();
        redir_now = 1; redir_tgt = 56'h2004;
        cycle();
        lat_fixed = 0;
        wait_req(16, 56'h2000, "miss_redirect_req");
        check_eq("miss_dropped", bus.bundle_valid, 0);

        // Redirect coincident with the response for 0x1008
        do_reset(0);
        wait_req(4, 56'h1000, "coin_req0");
        redir_on_done = 1; redir_tgt = 56'h2000; watch_1008 = 1; saw_1008 = 0;
        wait_req(4, 56'h1008, "coin_req1");
        wait_req(6, 56'h2000, "coin_redirect_req");
        repeat (4) cycle();
        check_eq("coin_no_1008", saw_1008, 0);
        watch_1008 = 0;

        // PC wraps at the top of the address space
        redir_now = 1; redir_tgt = 56'hFF_FFFF_FFFF_FFFC;
        wait_req(10, 56'hFF_FFFF_FFFF_FFF8, "wrap_req");
        wait_req(6, 56'h0, "wrap_next_req");

        // Reset in the middle of a miss, stale done afterwards
        do_reset(0);
        lat_fixed = 20;
        wait_req(4, 56'h1000, "rmm_req");
        repeat (3) cycle();
        lat_fixed = 0;
        do_reset(1);
        wait_req(4, 56'h1000, "rmm_fresh_req");

        // Randomized traffic
        do_reset(0);
        ready_mode = 2; lat_fixed = -1; redir_pct = 6;
        repeat (3000) cycle();
        redir_pct = 0; ready_mode = 1;
        repeat (30) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
